mc_controller: RTL and testbench
================================

MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 Parameter ALUOP_W, default 3: width of ALUoperation; values ≥3, codes zero-extended.
REQ-002 Parameter MEM_HS, default 1: 1 = memory states wait on mem_ready; 0 = mem_ready ignored, taken as 1.
REQ-003 Parameter TRAP_EN, default 1: 1 = illegal opcode/funct enters TRAP; 0 = illegal decodes return to IF.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 instruction  input  32  IR contents; opcode [31:26], funct [5:0].
REQ-007 zeroflag  input  1  ALU zero result.
REQ-008 mem_ready  input  1  memory access completes this cycle.
REQ-009 PCWrite, PCWriteCond, IorD, MemWrite, MemRead, IRWrite, RegDst, WriteRegSel, MemtoReg, WriteDataSel, RegWrite, ALUSrcA  output  1 each  datapath strobes/selects.
REQ-010 ALUSrcB, PCSrc  output  2 each  mux selects.
REQ-011 ALUoperation  output  ALUOP_W  ALU op (add 010, sub 110, and 000, or 001, slt 111).
REQ-012 illegal  output  1  high while in TRAP.
REQ-013 state  output  4  current state code, debug.

Function
REQ-014 Outputs are Moore on state, plus Mealy on mem_ready/zeroflag where stated; all strobes default 0 in every state.
REQ-015 States: IF, ID, JMP, JAL, JR, BR, EX_R, EX_I, WB_R, WB_I, MEM_ADR, MEM_RD, MEM_WR, WB_LW, TRAP.
REQ-016 IF: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, add; IRWrite and PCWrite=mem_ready; stays in IF until mem_ready=1, then ID.
REQ-017 ID: ALUSrcA=0, ALUSrcB=11, add; next by opcode: 000000 → JR if funct=001000, else EX_R; 000010 JMP; 000011 JAL; 000100/000101 BR; 001000/001100/001101/001010 EX_I; 100011/101011 MEM_ADR; other → TRAP (TRAP_EN=1) or IF.
REQ-018 EX_R: ALUSrcA=1, ALUSrcB=00; funct 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt, other → TRAP/IF with no write; else → WB_R.
REQ-019 EX_I: ALUSrcA=1, ALUSrcB=10; addi add, andi and, ori or, slti slt; → WB_I.
REQ-020 WB_R: RegDst=1, RegWrite=1 → IF. WB_I: RegDst=0, RegWrite=1 → IF.
REQ-021 BR: ALUSrcA=1, ALUSrcB=00, sub, PCSrc=10; PCWrite = zeroflag (beq) or ~zeroflag (bne); PCWriteCond=0; → IF.
REQ-022 JMP: PCSrc=01, PCWrite=1 → IF. JR: PCSrc=11, PCWrite=1 → IF.
REQ-023 JAL: WriteRegSel=1, WriteDataSel=1, RegWrite=1, PCSrc=01, PCWrite=1, single cycle → IF.
REQ-024 MEM_ADR: ALUSrcA=1, ALUSrcB=10, add; lw → MEM_RD, sw → MEM_WR.
REQ-025 MEM_RD: IorD=1, MemRead=1; waits for mem_ready, then → WB_LW. WB_LW: MemtoReg=1, RegWrite=1 → IF.
REQ-026 MEM_WR: IorD=1, MemWrite=1 held until mem_ready=1, then → IF.
REQ-027 TRAP: all strobes 0, illegal=1; exit only by reset.
REQ-028 Latency with mem_ready always 1: R/I 4 cycles, lw 5, sw 4, branch/jump/jr/jal 3.
REQ-029 instruction changes while not in IF/ID are not filtered; datapath holds IR stable.

Reset
REQ-030 rst=0 forces state=IF asynchronously; registered state only.
REQ-031 In reset all outputs follow IF decode with mem_ready applied; illegal=0.
REQ-032 Reset mid-access abandons the access; first cycle after release is IF.

Structure
REQ-033 Package mc_ctrl_pkg: opcode/funct constants, state encoding, ALU op codes.
REQ-034 Sub-module mc_alu_decoder: combinational opcode/funct → ALU op + valid flag, used by EX_R/EX_I.

Verification
REQ-035 add (op 0, funct 100000), mem_ready=1 → IF,ID,EX_R,WB_R; RegDst=1, RegWrite=1 in cycle 4; ALUoperation=010 in cycle 3.
REQ-036 lw, mem_ready low 3 cycles in MEM_RD → MemRead held 4 cycles, WB_LW once, MemtoReg=1, total 8 cycles.
REQ-037 bne with zeroflag=0 → PCWrite=1 in BR; zeroflag=1 → PCWrite=0; beq inverted.
REQ-038 opcode 111111 → TRAP, illegal=1 for 10 cycles; rst=0 → state=IF, illegal=0 immediately.
REQ-039 IF with mem_ready=0 for 2 cycles → IRWrite/PCWrite=0 then 1 in third cycle; MEM_HS=0 build ignores mem_ready.
REQ-040 jal → JAL cycle: RegWrite=1, WriteRegSel=1, PCSrc=01, PCWrite=1; ALUOP_W=5 build shows 00010 for add.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle controller: opcodes, functs, FSM states,
// ALU operation codes and mux select values.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_IF      = 4'd0,
    ST_ID      = 4'd1,
    ST_JMP     = 4'd2,
    ST_JAL     = 4'd3,
    ST_JR      = 4'd4,
    ST_BR      = 4'd5,
    ST_EX_R    = 4'd6,
    ST_EX_I    = 4'd7,
    ST_WB_R    = 4'd8,
    ST_WB_I    = 4'd9,
    ST_MEM_ADR = 4'd10,
    ST_MEM_RD  = 4'd11,
    ST_MEM_WR  = 4'd12,
    ST_WB_LW   = 4'd13,
    ST_TRAP    = 4'd14
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_JR  = 6'b001000;
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_BOFF = 2'b11;

  localparam logic [1:0] PC_ALU  = 2'b00;
  localparam logic [1:0] PC_JUMP = 2'b01;
  localparam logic [1:0] PC_BR   = 2'b10;
  localparam logic [1:0] PC_REG  = 2'b11;

  // Where an undecodable instruction goes: trap state, or quietly back to fetch.
  function automatic state_e illegal_dest(input logic trap_en);
    if (trap_en) begin
      return ST_TRAP;
    end else begin
      return ST_IF;
    end
  endfunction

  // State following ID for a given opcode/funct pair.
  function automatic state_e id_next(input logic [5:0] opcode, input logic [5:0] funct,
                                     input logic trap_en);
    state_e nxt;
    case (opcode)
      OP_RTYPE: begin
        if (funct == FN_JR) begin
          nxt = ST_JR;
        end else begin
          nxt = ST_EX_R;
        end
      end
      OP_J:                                     nxt = ST_JMP;
      OP_JAL:                                   nxt = ST_JAL;
      OP_BEQ, OP_BNE:                           nxt = ST_BR;
      OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI:        nxt = ST_EX_I;
      OP_LW, OP_SW:                             nxt = ST_MEM_ADR;
      default:                                  nxt = illegal_dest(trap_en);
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/mc_alu_decoder.sv
// Combinational ALU-control decode: R-type functs and I-type opcodes map to an
// ALU operation plus a flag saying the combination is supported.
module mc_alu_decoder
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic [2:0] alu_op,
  output logic       alu_valid
);

  // Decode funct for R-type, opcode otherwise.
  always_comb begin
    alu_op    = ALU_ADD;
    alu_valid = 1'b0;
    if (opcode == OP_RTYPE) begin
      case (funct)
        FN_ADD:  begin alu_op = ALU_ADD; alu_valid = 1'b1; end
        FN_SUB:  begin alu_op = ALU_SUB; alu_valid = 1'b1; end
        FN_AND:  begin alu_op = ALU_AND; alu_valid = 1'b1; end
        FN_OR:   begin alu_op = ALU_OR;  alu_valid = 1'b1; end
        FN_SLT:  begin alu_op = ALU_SLT; alu_valid = 1'b1; end
        default: begin alu_op = ALU_ADD; alu_valid = 1'b0; end
      endcase
    end else begin
      case (opcode)
        OP_ADDI: begin alu_op = ALU_ADD; alu_valid = 1'b1; end
        OP_ANDI: begin alu_op = ALU_AND; alu_valid = 1'b1; end
        OP_ORI:  begin alu_op = ALU_OR;  alu_valid = 1'b1; end
        OP_SLTI: begin alu_op = ALU_SLT; alu_valid = 1'b1; end
        default: begin alu_op = ALU_ADD; alu_valid = 1'b0; end
      endcase
    end
  end

endmodule

// File: rtl/mc_controller.sv
// Multicycle MIPS-style control FSM. Outputs are decoded from the registered
// state, with mem_ready/zeroflag qualifying the strobes that depend on them.
module mc_controller
  import mc_ctrl_pkg::*;
#(
  parameter int ALUOP_W = 3,
  parameter int MEM_HS  = 1,
  parameter int TRAP_EN = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        instruction,
  input  logic               zeroflag,
  input  logic               mem_ready,
  output logic               PCWrite,
  output logic               PCWriteCond,
  output logic               IorD,
  output logic               MemWrite,
  output logic               MemRead,
  output logic               IRWrite,
  output logic               RegDst,
  output logic               WriteRegSel,
  output logic               MemtoReg,
  output logic               WriteDataSel,
  output logic               RegWrite,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         PCSrc,
  output logic [ALUOP_W-1:0] ALUoperation,
  output logic               illegal,
  output logic [3:0]         state
);

  state_e      state_q, state_d;
  logic [5:0]  opcode_s, funct_s;
  logic        mem_rdy_s;
  logic        trap_en_s;
  logic [2:0]  dec_op_s, alu_op_s;
  logic        dec_valid_s;
  logic        unused_ir_s;

  assign opcode_s  = instruction[31:26];
  assign funct_s   = instruction[5:0];
  assign mem_rdy_s = (MEM_HS != 0) ? mem_ready : 1'b1;
  assign trap_en_s = (TRAP_EN != 0);
  // Register/immediate fields are consumed by the datapath only.
  assign unused_ir_s = ^instruction[25:6];

  mc_alu_decoder u_alu_dec (
    .opcode    (opcode_s),
    .funct     (funct_s),
    .alu_op    (dec_op_s),
    .alu_valid (dec_valid_s)
  );

  // State register; reset lands in fetch and abandons any access in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IF;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and output decode, every strobe defaulting low.
  always_comb begin
    state_d      = state_q;
    PCWrite      = 1'b0;
    PCWriteCond  = 1'b0;
    IorD         = 1'b0;
    MemWrite     = 1'b0;
    MemRead      = 1'b0;
    IRWrite      = 1'b0;
    RegDst       = 1'b0;
    WriteRegSel  = 1'b0;
    MemtoReg     = 1'b0;
    WriteDataSel = 1'b0;
    RegWrite     = 1'b0;
    ALUSrcA      = 1'b0;
    ALUSrcB      = SRCB_REG;
    PCSrc        = PC_ALU;
    alu_op_s     = ALU_AND;
    illegal      = 1'b0;
    case (state_q)
      ST_IF: begin
        MemRead  = 1'b1;
        ALUSrcB  = SRCB_FOUR;
        alu_op_s = ALU_ADD;
        IRWrite  = mem_rdy_s;
        PCWrite  = mem_rdy_s;
        if (mem_rdy_s) begin
          state_d = ST_ID;
        end else begin
          state_d = ST_IF;
        end
      end
      ST_ID: begin
        ALUSrcB  = SRCB_BOFF;
        alu_op_s = ALU_ADD;
        state_d  = id_next(opcode_s, funct_s, trap_en_s);
      end
      ST_EX_R, ST_EX_I: begin
        ALUSrcA  = 1'b1;
        ALUSrcB  = (state_q == ST_EX_I) ? SRCB_IMM : SRCB_REG;
        alu_op_s = dec_op_s;
        if (!dec_valid_s) begin
          state_d = illegal_dest(trap_en_s);
        end else if (state_q == ST_EX_I) begin
          state_d = ST_WB_I;
        end else begin
          state_d = ST_WB_R;
        end
      end
      ST_WB_R: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
        state_d  = ST_IF;
      end
      ST_WB_I: begin
        RegWrite = 1'b1;
        state_d  = ST_IF;
      end
      ST_BR: begin
        ALUSrcA  = 1'b1;
        alu_op_s = ALU_SUB;
        PCSrc    = PC_BR;
        if (opcode_s == OP_BNE) begin
          PCWrite = ~zeroflag;
        end else begin
          PCWrite = zeroflag;
        end
        state_d = ST_IF;
      end
      ST_JMP: begin
        PCSrc   = PC_JUMP;
        PCWrite = 1'b1;
        state_d = ST_IF;
      end
      ST_JR: begin
        PCSrc   = PC_REG;
        PCWrite = 1'b1;
        state_d = ST_IF;
      end
      ST_JAL: begin
        WriteRegSel  = 1'b1;
        WriteDataSel = 1'b1;
        RegWrite     = 1'b1;
        PCSrc        = PC_JUMP;
        PCWrite      = 1'b1;
        state_d      = ST_IF;
      end
      ST_MEM_ADR: begin
        ALUSrcA  = 1'b1;
        ALUSrcB  = SRCB_IMM;
        alu_op_s = ALU_ADD;
        if (opcode_s == OP_LW) begin
          state_d = ST_MEM_RD;
        end else if (opcode_s == OP_SW) begin
          state_d = ST_MEM_WR;
        end else begin
          state_d = illegal_dest(trap_en_s);
        end
      end
      ST_MEM_RD: begin
        IorD    = 1'b1;
        MemRead = 1'b1;
        if (mem_rdy_s) begin
          state_d = ST_WB_LW;
        end else begin
          state_d = ST_MEM_RD;
        end
      end
      ST_MEM_WR: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
        if (mem_rdy_s) begin
          state_d = ST_IF;
        end else begin
          state_d = ST_MEM_WR;
        end
      end
      ST_WB_LW: begin
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
        state_d  = ST_IF;
      end
      ST_TRAP: begin
        illegal = 1'b1;
        state_d = ST_TRAP;
      end
      // Unused encoding: treat as a corrupted state.
      default: begin
        state_d = illegal_dest(trap_en_s);
      end
    endcase
  end

  assign ALUoperation = ALUOP_W'(alu_op_s);
  assign state        = state_q;

endmodule

// File: tb/tb_mc_controller.sv
// Scoreboard bench for mc_controller: a default build plus a MEM_HS=0,
// ALUOP_W=5, TRAP_EN=0 build exercised while the first is held in reset.
module tb_mc_controller;
  import mc_ctrl_pkg::*;

  localparam logic [11:0] PCW = 12'h800, PCWC = 12'h400, IORD = 12'h200, MW  = 12'h100;
  localparam logic [11:0] MR  = 12'h080, IRW  = 12'h040, RD   = 12'h020, WRS = 12'h010;
  localparam logic [11:0] M2R = 12'h008, WDS  = 12'h004, RW   = 12'h002, ASA = 12'h001;
  localparam logic [11:0] NONE = 12'h000;

  logic        clk = 1'b0;
  logic        rst, rst2, zeroflag, mem_ready, mem_ready2;
  logic [31:0] instruction;

  logic        a_pcw, a_pcwc, a_iord, a_mw, a_mr, a_irw, a_rd, a_wrs, a_m2r, a_wds, a_rw, a_asa, a_ill;
  logic [1:0]  a_srcb, a_pcsrc;
  logic [2:0]  a_alu;
  logic [3:0]  a_st;
  logic        b_pcw, b_pcwc, b_iord, b_mw, b_mr, b_irw, b_rd, b_wrs, b_m2r, b_wds, b_rw, b_asa, b_ill;
  logic [1:0]  b_srcb, b_pcsrc;
  logic [4:0]  b_alu;
  logic [3:0]  b_st;

  mc_controller dut (
    .clk(clk), .rst(rst), .instruction(instruction), .zeroflag(zeroflag), .mem_ready(mem_ready),
    .PCWrite(a_pcw), .PCWriteCond(a_pcwc), .IorD(a_iord), .MemWrite(a_mw), .MemRead(a_mr),
    .IRWrite(a_irw), .RegDst(a_rd), .WriteRegSel(a_wrs), .MemtoReg(a_m2r),
    .WriteDataSel(a_wds), .RegWrite(a_rw), .ALUSrcA(a_asa), .ALUSrcB(a_srcb),
    .PCSrc(a_pcsrc), .ALUoperation(a_alu), .illegal(a_ill), .state(a_st)
  );

  mc_controller #(.ALUOP_W(5), .MEM_HS(0), .TRAP_EN(0)) dut2 (
    .clk(clk), .rst(rst2), .instruction(instruction), .zeroflag(zeroflag), .mem_ready(mem_ready2),
    .PCWrite(b_pcw), .PCWriteCond(b_pcwc), .IorD(b_iord), .MemWrite(b_mw), .MemRead(b_mr),
    .IRWrite(b_irw), .RegDst(b_rd), .WriteRegSel(b_wrs), .MemtoReg(b_m2r),
    .WriteDataSel(b_wds), .RegWrite(b_rw), .ALUSrcA(b_asa), .ALUSrcB(b_srcb),
    .PCSrc(b_pcsrc), .ALUoperation(b_alu), .illegal(b_ill), .state(b_st)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          which;
    logic [3:0]  st;
    logic [11:0] s1;
    logic [1:0]  srcb;
    logic [1:0]  pcsrc;
    logic [4:0]  alu;
    bit          care;
    logic        ill;
    string       tag;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  exp_t        cur;
  logic [3:0]  g_st;
  logic [11:0] g_s1;
  logic [1:0]  g_srcb, g_pcsrc;
  logic [4:0]  g_alu;
  logic        g_ill;
  bit          ok;

  // Monitor: every negedge with a pending expectation compares one cycle.
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      cur = sb_q.pop_front();
      if (cur.which) begin
        g_st = b_st; g_srcb = b_srcb; g_pcsrc = b_pcsrc; g_alu = b_alu; g_ill = b_ill;
        g_s1 = {b_pcw, b_pcwc, b_iord, b_mw, b_mr, b_irw, b_rd, b_wrs, b_m2r, b_wds, b_rw, b_asa};
      end else begin
        g_st = a_st; g_srcb = a_srcb; g_pcsrc = a_pcsrc; g_alu = {2'b00, a_alu}; g_ill = a_ill;
        g_s1 = {a_pcw, a_pcwc, a_iord, a_mw, a_mr, a_irw, a_rd, a_wrs, a_m2r, a_wds, a_rw, a_asa};
      end
      ok = (g_st == cur.st) && (g_s1 == cur.s1) && (g_srcb == cur.srcb) &&
           (g_pcsrc == cur.pcsrc) && (g_ill == cur.ill) && (!cur.care || (g_alu == cur.alu));
      n_cmp++;
      if (!ok) begin
        n_bad++;
        $display("FAIL %s (dut%0d): got st=%0d strobes=%03h srcb=%b pcsrc=%b alu=%b ill=%b; want st=%0d strobes=%03h srcb=%b pcsrc=%b alu=%b(care=%0d) ill=%b",
                 cur.tag, cur.which, g_st, g_s1, g_srcb, g_pcsrc, g_alu, g_ill,
                 cur.st, cur.s1, cur.srcb, cur.pcsrc, cur.alu, cur.care, cur.ill);
      end
    end
  end

  // Drive this cycle's inputs, queue its expected outputs, advance one clock.
  task automatic chk(input bit which, input state_e st, input logic [11:0] s1,
                     input logic [1:0] srcb, input logic [1:0] pcsrc, input logic [4:0] alu,
                     input bit care, input logic ill, input logic mr, input logic zf,
                     input string tag);
    exp_t e;
    mem_ready = mr;
    zeroflag  = zf;
    e.which = which; e.st = st; e.s1 = s1; e.srcb = srcb; e.pcsrc = pcsrc;
    e.alu = alu; e.care = care; e.ill = ill; e.tag = tag;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [5:0] fn);
    return {op, 20'h12345, fn};
  endfunction

  task automatic fetch(input bit which, input logic [31:0] ins);
    instruction = ins;
    chk(which, ST_IF, MR | IRW | PCW, 2'b01, 2'b00, 5'b00010, 1'b1, 1'b0, 1'b1, 1'b0, "fetch");
  endtask

  task automatic decode(input bit which);
    chk(which, ST_ID, NONE, 2'b11, 2'b00, 5'b00010, 1'b1, 1'b0, 1'b1, 1'b0, "decode");
  endtask

  logic [5:0] r_fn [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
  logic [4:0] r_alu[5] = '{5'b00010, 5'b00110, 5'b00000, 5'b00001, 5'b00111};
  logic [5:0] i_op [4] = '{6'b001000, 6'b001100, 6'b001101, 6'b001010};
  logic [4:0] i_alu[4] = '{5'b00010, 5'b00000, 5'b00001, 5'b00111};
  logic [5:0] b_op [4] = '{6'b000101, 6'b000101, 6'b000100, 6'b000100};
  logic       b_zf [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
  logic [11:0] b_pc[4] = '{PCW, NONE, PCW, NONE};

  initial begin
    rst = 1'b0; rst2 = 1'b0; mem_ready = 1'b1; mem_ready2 = 1'b0; zeroflag = 1'b0;
    instruction = 32'h0000_0000;
    repeat (2) @(posedge clk);
    #1;
    chk(1'b0, ST_IF, MR | IRW | PCW, 2'b01, 2'b00, 5'b00010, 1'b1, 1'b0, 1'b1, 1'b0, "reset_if");
    rst = 1'b1;

    for (int i = 0; i < 5; i++) begin
      fetch(1'b0, mk(6'b000000, r_fn[i]));
      decode(1'b0);
      chk(1'b0, ST_EX_R, ASA, 2'b00, 2'b00, r_alu[i], 1'b1, 1'b0, 1'b1, 1'b0, "ex_r");
      chk(1'b0, ST_WB_R, RD | RW, 2'b00, 2'b00, 5'b0, 1'b0, 1'b0, 1'b1, 1'b0, "wb_r");
    end

    for (int i = 0; i < 4; i++) begin
      fetch(1'b0, mk(i_op[i], 6'b000111));
      decode(1'b0);
      chk(1'b0, ST_EX_I, ASA, 2'b10, 2'b00, i_alu[i], 1'b1, 1'b0, 1'b1, 1'b0, "ex_i");
      chk(1'b0, ST_WB_I, RW, 2'b00, 2'b00, 5'b0, 1'b0, 1'b0, 1'b1, 1'b0, "wb_i");
    end

    // lw with a three-cycle memory stall: 8 cycles total
    fetch(1'b0, mk(6'b100011, 6'b000100));
    decode(1'b0);
    chk(1'b0, ST_MEM_ADR, ASA, 2'b10, 2'b00, 5'b00010, 1'b1, 1'b0, 1'b1, 1'b0, "lw_adr");
    for (int i = 0; i < 3; i++)
      chk(1'b0, ST_MEM_RD, IORD | MR, 2'b00, 2'b00, 5'b0, 1'b0, 1'b0, 1'b0, 1'b0, "lw_wait");
    chk(1'b0, ST_MEM_RD, IORD | MR, 2'b00, 2'b00, 5'b0, 1'b0, 1'b0, 1'b1, 1'b0, "lw_rd");
    chk(1'b0, ST_WB_LW, M2R | RW, 2'b00, 2'b00, 5'b0, 1'b0, 1'b0, 1'b1, 1'b0, "lw_wb");

    fetch(1'b0, mk(6'b101011, 6'b000100));
    decode(1'b0);
    chk(1'b0, ST_MEM_ADR, ASA, 2'b10, 2'b00, 5'b00010, 1'b1, 1'b0, 1'b1, 1'b0, "sw_adr");
    chk(1'b0, ST_MEM_WR, IORD | MW, 2'b00, 2'b00, 5'b0, 1'b0, 1'b0, 1'b0, 1'b0, "sw_wait");
    chk(1'b0, ST_MEM_WR, IORD | MW, 2'b00, 2'b00, 5'b0, 1'b0, 1'b0, 1'b1, 1'b0, "sw_wr");

    for (int i = 0; i < 4; i++) begin
      fetch(1'b0, mk(b_op[i], 6'b000011));
      decode(1'b0);
      chk(1'b0, ST_BR, ASA | b_pc[i], 2'b00, 2'b10, 5'b00110, 1'b1, 1'b0, 1'b1, b_zf[i], "branch");
    end

    // fetch stalled two cycles, then a jump
    instruction = mk(6'b000010, 6'b000000);
    chk(1'b0, ST_IF, MR, 2'b01, 2'b00, 5'b00010, 1'b1, 1'b0, 1'b0, 1'b0, "if_stall");
    chk(1'b0, ST_IF, MR, 2'b01, 2'b00, 5'b00010, 1'b1, 1'b0, 1'b0, 1'b0, "if_stall");
    chk(1'b0, ST_IF, MR | IRW | PCW, 2'b01, 2'b00, 5'b00010, 1'b1, 1'b0, 1'b1, 1'b0, "if_go");
    decode(1'b0);
    chk(1'b0, ST_JMP, PCW, 2'b00, 2'b01, 5'b0, 1'b0, 1'b0, 1'b1, 1'b0, "jmp");

    fetch(1'b0, mk(6'b000000, 6'b001000));
    decode(1'b0);
    chk(1'b0, ST_JR, PCW, 2'b00, 2'b11, 5'b0, 1'b0, 1'b0, 1'b1, 1'b0, "jr");

    fetch(1'b0, mk(6'b000011, 6'b000000));
    decode(1'b0);
    chk(1'b0, ST_JAL, PCW | WRS | WDS | RW, 2'b00, 2'b01, 5'b0, 1'b0, 1'b0, 1'b1, 1'b0, "jal");

    // unsupported funct traps from EX_R without a write-back
    fetch(1'b0, mk(6'b000000, 6'b000000));
    decode(1'b0);
    chk(1'b0, ST_EX_R, ASA, 2'b00, 2'b00, 5'b0, 1'b0, 1'b0, 1'b1, 1'b0, "ex_r_bad");
    chk(1'b0, ST_TRAP, NONE, 2'b00, 2'b00, 5'b0, 1'b0, 1'b1, 1'b1, 1'b0, "trap_funct");
    rst = 1'b0;
    chk(1'b0, ST_IF, MR | IRW | PCW, 2'b01, 2'b00, 5'b00010, 1'b1, 1'b0, 1'b1, 1'b0, "rst_trap1");
    rst = 1'b1;

    fetch(1'b0, mk(6'b111111, 6'b000000));
    decode(1'b0);
    for (int i = 0; i < 10; i++)
      chk(1'b0, ST_TRAP, NONE, 2'b00, 2'b00, 5'b0, 1'b0, 1'b1, 1'b1, 1'b0, "trap_op");
    #2;
    rst = 1'b0;
    chk(1'b0, ST_IF, MR | IRW | PCW, 2'b01, 2'b00, 5'b00010, 1'b1, 1'b0, 1'b1, 1'b0, "rst_trap2");

    // second build: no handshake, 5-bit ALU op, illegal opcode returns to IF
    rst2 = 1'b1;
    fetch(1'b1, mk(6'b000000, 6'b100000));
    decode(1'b1);
    chk(1'b1, ST_EX_R, ASA, 2'b00, 2'b00, 5'b00010, 1'b1, 1'b0, 1'b0, 1'b0, "b_ex_r");
    chk(1'b1, ST_WB_R, RD | RW, 2'b00, 2'b00, 5'b0, 1'b0, 1'b0, 1'b0, 1'b0, "b_wb_r");
    fetch(1'b1, mk(6'b111111, 6'b000000));
    decode(1'b1);
    fetch(1'b1, mk(6'b100011, 6'b000000));
    decode(1'b1);
    chk(1'b1, ST_MEM_ADR, ASA, 2'b10, 2'b00, 5'b00010, 1'b1, 1'b0, 1'b0, 1'b0, "b_adr");
    chk(1'b1, ST_MEM_RD, IORD | MR, 2'b00, 2'b00, 5'b0, 1'b0, 1'b0, 1'b0, 1'b0, "b_rd");
    chk(1'b1, ST_WB_LW, M2R | RW, 2'b00, 2'b00, 5'b0, 1'b0, 1'b0, 1'b0, 1'b0, "b_wb_lw");
    fetch(1'b1, mk(6'b000000, 6'b100000));

    repeat (2) @(posedge clk);
    if (sb_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
